glossy_round_ctrl: RTL

//  Synthesizable round sequencer for N-node Glossy flood experiments.
//  - Starts NUM_NODES glossy_app instances together, then waits for every node's done.
//  - Collects per-round completion mask, latency and pass/fail; repeats for NUM_ROUNDS.
//  - Replaces ad-hoc start/done-count logic; usable on-chip and in benches.

---
 rtl/glossy_round_ctrl_pkg.sv | 14 +
 rtl/glossy_round_ctrl_if.sv | 31 +++
 rtl/glossy_edge_det.sv | 18 +
 rtl/glossy_round_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/glossy_round_ctrl_pkg.sv
// rtl/glossy_round_ctrl_pkg.sv - shared state encoding for the Glossy round sequencer
package glossy_round_ctrl_pkg;

    localparam int GR_STATE_W = 3;

    typedef enum logic [GR_STATE_W-1:0] {
        GR_IDLE   = 3'd0,
        GR_START  = 3'd1,
        GR_WAIT   = 3'd2,
        GR_GAP    = 3'd3,
        GR_FINISH = 3'd4
    } gr_state_e;

endpackage

// File: rtl/glossy_round_ctrl_if.sv
// rtl/glossy_round_ctrl_if.sv - node start/done and per-round result bundle
interface glossy_round_ctrl_if #(
    parameter int NUM_NODES = 2,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
);
    logic                 i_enable;
    logic [NUM_NODES-1:0] i_node_done;
    logic [NUM_NODES-1:0] o_start;
    logic                 o_busy;
    logic                 o_round_done;
    logic                 o_round_ok;
    logic [NUM_NODES-1:0] o_round_mask;
    logic [TIMEOUT_W-1:0] o_latency;
    logic [CNT_W-1:0]     o_round_cnt;
    logic                 o_finished;
    logic [CNT_W-1:0]     o_fail_cnt;
    logic [TIMEOUT_W-1:0] o_max_lat;

    modport master (
        input  i_enable, i_node_done,
        output o_start, o_busy, o_round_done, o_round_ok, o_round_mask,
               o_latency, o_round_cnt, o_finished, o_fail_cnt, o_max_lat
    );

    modport slave (
        output i_enable, i_node_done,
        input  o_start, o_busy, o_round_done, o_round_ok, o_round_mask,
               o_latency, o_round_cnt, o_finished, o_fail_cnt, o_max_lat
    );
endinterface

// File: rtl/glossy_edge_det.sv
// rtl/glossy_edge_det.sv - registered vector rising-edge detector
module glossy_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] prev;

    // Reset also loads the live input, so a level already high is never an edge.
    always_ff @(posedge clk) begin
        prev <= din;
    end

    assign rise = reset ? '0 : (din & ~prev);
endmodule

// File: rtl/glossy_round_ctrl.sv
// rtl/glossy_round_ctrl.sv - round sequencer for N-node Glossy floods
// Optional statistics outputs enabled by GLOSSY_ROUND_STATS_EN.
module glossy_round_ctrl
    import glossy_round_ctrl_pkg::*;
#(
    parameter int NUM_NODES      = 2,
    parameter int NUM_ROUNDS     = 4,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GAP_CYCLES     = 100,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    glossy_round_ctrl_if.master bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [NUM_NODES-1:0] ALL_DONE = '1;
    localparam logic [TIMEOUT_W-1:0] LAT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] LAT_FAIL = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]     ROUNDS   = CNT_W'(NUM_ROUNDS);

    gr_state_e            state;
    logic [TIMEOUT_W-1:0] lat_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [NUM_NODES-1:0] acc_mask;
    logic [NUM_NODES-1:0] done_rise;
    logic [NUM_NODES-1:0] mask_now;
    logic                 en_rise;
    logic                 full, wait_live, fin_ok, fin_fail, launch;
    logic [CNT_W-1:0]     cnt_next;

    glossy_edge_det #(.WIDTH(NUM_NODES)) u_done_det (
        .clk(clk), .reset(reset), .din(bus.i_node_done), .rise(done_rise)
    );

    glossy_edge_det #(.WIDTH(1)) u_en_det (
        .clk(clk), .reset(reset), .din(bus.i_enable), .rise(en_rise)
    );

    // Edges count in the cycle they appear, so the completing edge sees its own counter value.
    assign mask_now  = acc_mask | done_rise;
    assign full      = (mask_now == ALL_DONE);
    assign wait_live = (state == GR_WAIT) && bus.i_enable;
    assign fin_ok    = wait_live && full;
    assign fin_fail  = wait_live && !full && (lat_cnt == LAT_LAST);
    assign launch    = (state == GR_IDLE) && en_rise;
    assign cnt_next  = (bus.o_round_cnt == '1) ? bus.o_round_cnt
                                               : bus.o_round_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= GR_IDLE;
            lat_cnt           <= '0;
            gap_cnt           <= '0;
            acc_mask          <= '0;
            bus.o_start       <= '0;
            bus.o_busy        <= 1'b0;
            bus.o_round_done  <= 1'b0;
            bus.o_round_ok    <= 1'b0;
            bus.o_round_mask  <= '0;
            bus.o_latency     <= '0;
            bus.o_round_cnt   <= '0;
            bus.o_finished    <= 1'b0;
        end else begin
            bus.o_start      <= '0;
            bus.o_round_done <= 1'b0;
            case (state)
                GR_IDLE: begin
                    if (launch) begin
                        state            <= GR_START;
                        bus.o_busy       <= 1'b1;
                        bus.o_round_cnt  <= '0;
                        bus.o_finished   <= 1'b0;
                        bus.o_round_mask <= '0;
                    end
                end
                GR_START: begin
                    if (!bus.i_enable) begin
                        state      <= GR_IDLE;
                        bus.o_busy <= 1'b0;
                    end else begin
                        bus.o_start <= '1;
                        lat_cnt     <= '0;
                        acc_mask    <= '0;
                        state       <= GR_WAIT;
                    end
                end
                GR_WAIT: begin
                    if (!bus.i_enable) begin
                        state      <= GR_IDLE;
                        bus.o_busy <= 1'b0;
                    end else begin
                        lat_cnt  <= lat_cnt + TIMEOUT_W'(1);
                        acc_mask <= mask_now;
                        if (fin_ok || fin_fail) begin
                            bus.o_round_done <= 1'b1;
                            bus.o_round_ok   <= fin_ok;
                            bus.o_round_mask <= mask_now;
                            bus.o_latency    <= fin_ok ? lat_cnt : LAT_FAIL;
                            bus.o_round_cnt  <= cnt_next;
                            gap_cnt          <= '0;
                            state            <= GR_GAP;
                        end
                    end
                end
                GR_GAP: begin
                    if (!bus.i_enable) begin
                        state      <= GR_IDLE;
                        bus.o_busy <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        if ((NUM_ROUNDS != 0) && (bus.o_round_cnt == ROUNDS)) begin
                            state          <= GR_FINISH;
                            bus.o_finished <= 1'b1;
                            bus.o_busy     <= 1'b0;
                        end else begin
                            state <= GR_START;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                GR_FINISH: begin
                    if (!bus.i_enable) state <= GR_IDLE;
                end
                default: state <= GR_IDLE;
            endcase
        end
    end

`ifdef GLOSSY_ROUND_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            bus.o_fail_cnt <= '0;
            bus.o_max_lat  <= '0;
        end else begin
            if (fin_fail && (bus.o_fail_cnt != '1))
                bus.o_fail_cnt <= bus.o_fail_cnt + CNT_W'(1);
            if (fin_ok && (lat_cnt > bus.o_max_lat))
                bus.o_max_lat <= lat_cnt;
        end
    end
`else
    assign bus.o_fail_cnt = '0;
    assign bus.o_max_lat  = '0;
`endif
endmodule
